// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_types
// Description : Shared types for the CDB and its consumers.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    localparam int c_ROB_DEPTH = 32;
    localparam int c_TAG_W     = $clog2(c_ROB_DEPTH);
    localparam int c_DATA_W    = 32;

    // Requester index on the CDB
    typedef enum logic [1:0] {
        CDB_ADD = 2'd0,
        CDB_MUL = 2'd1,
        CDB_LSQ = 2'd2,
        CDB_BP  = 2'd3
    } cdb_src_t;

    typedef struct packed {
        logic                valid;
        logic [c_TAG_W-1:0]  tag;
        logic [c_DATA_W-1:0] data;
    } cdb_bus_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational one-hot round-robin select starting at i_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant
);

    logic w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : One-entry holding register per result producer, round-robin
//               broadcast of one entry per cycle onto the common data bus.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int ROB_DEPTH = 32,
    parameter  int DATA_W    = 32,
    localparam int TAG_W     = $clog2(ROB_DEPTH),
    localparam int SRC_W     = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]          cdb_src,
    output logic [N_REQ-1:0]          cdb_grant
);

    logic [N_REQ-1:0]  r_hold_v;
    logic [TAG_W-1:0]  r_hold_tag  [N_REQ];
    logic [DATA_W-1:0] r_hold_data [N_REQ];
    logic [SRC_W-1:0]  r_rr_ptr;

    logic [N_REQ-1:0]  w_grant;
    logic [SRC_W-1:0]  w_next_ptr;

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (SRC_W)
    ) u_rr_arbiter (
        .i_req   (r_hold_v),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant)
    );

    // A flush suppresses the broadcast and blocks acceptance for that cycle.
    assign cdb_grant = flush ? '0 : w_grant;
    assign cdb_valid = |cdb_grant;
    assign req_ready = flush ? '0 : (~r_hold_v | w_grant);

    always_comb begin
        cdb_tag    = '0;
        cdb_data   = '0;
        cdb_src    = '0;
        w_next_ptr = r_rr_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (cdb_grant[i]) begin
                cdb_tag    = cdb_tag  | r_hold_tag[i];
                cdb_data   = cdb_data | r_hold_data[i];
                cdb_src    = SRC_W'(i);
                w_next_ptr = (i == N_REQ - 1) ? '0 : SRC_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_v <= '0;
            r_rr_ptr <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_hold_tag[i]  <= '0;
                r_hold_data[i] <= '0;
            end
        end else if (flush) begin
            r_hold_v <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                // Refill wins over drain so a granted slot can stream.
                if (req_valid[i] && req_ready[i]) begin
                    r_hold_v[i]    <= 1'b1;
                    r_hold_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
                    r_hold_data[i] <= req_data[i*DATA_W +: DATA_W];
                end else if (cdb_grant[i]) begin
                    r_hold_v[i] <= 1'b0;
                end
            end
            if (cdb_valid) begin
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Directed scoreboard bench for cdb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
    import rv32i_types::*;

    localparam int c_N     = 4;
    localparam int c_TW    = 5;
    localparam int c_DW    = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [c_N-1:0]       req_valid;
    logic [c_N*c_TW-1:0]  req_tag;
    logic [c_N*c_DW-1:0]  req_data;
    logic [c_N-1:0]       req_ready;
    logic                 cdb_valid;
    logic [c_TW-1:0]      cdb_tag;
    logic [c_DW-1:0]      cdb_data;
    logic [1:0]           cdb_src;
    logic [c_N-1:0]       cdb_grant;

    typedef struct {
        logic [c_TW-1:0] tag;
        logic [c_DW-1:0] data;
        cdb_src_t        src;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    cdb_arbiter #(.N_REQ(c_N), .ROB_DEPTH(32), .DATA_W(c_DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src),
        .cdb_grant (cdb_grant)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_DW-1:0] dval(input int tag);
        return 32'hD000_0000 | 32'(tag * 32'h111);
    endfunction

    task automatic set_req(input int i, input int tag);
        req_valid[i]              = 1'b1;
        req_tag[i*c_TW +: c_TW]   = c_TW'(tag);
        req_data[i*c_DW +: c_DW]  = dval(tag);
    endtask

    task automatic expect_bc(input int tag, input cdb_src_t src);
        exp_t e;
        e.tag  = c_TW'(tag);
        e.data = dval(tag);
        e.src  = src;
        sb_q.push_back(e);
    endtask

    // Compare the bus just before the edge that commits it.
    task automatic check_cdb();
        cdb_bus_t obs;
        exp_t     e;
        obs = '{valid: cdb_valid, tag: cdb_tag, data: cdb_data};
        if (obs.valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_bcast_tag", 64'(obs.tag), 64'h3f);
            end else begin
                e = sb_q.pop_front();
                chk("bcast_tag",   64'(obs.tag),   64'(e.tag));
                chk("bcast_data",  64'(obs.data),  64'(e.data));
                chk("bcast_src",   64'(cdb_src),   64'(e.src));
                chk("bcast_grant", 64'(cdb_grant), 64'(4'b0001 << e.src));
            end
        end else begin
            chk("idle_zero", {cdb_grant, cdb_src, cdb_tag, cdb_data}, 64'h0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cdb();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        req_valid = '0; req_tag = '0; req_data = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_ready", 64'(req_ready), 64'hF);
        chk("reset_valid", 64'(cdb_valid), 64'h0);
        chk("reset_ptr",   64'(dut.r_rr_ptr), 64'h0);

        // Single request on the add slot
        set_req(0, 5); expect_bc(5, CDB_ADD);
        chk("single_data_val", 64'(dval(5)), 64'hD000_0555);
        tick();
        req_valid = '0;
        tick();
        chk("single_ptr", 64'(dut.r_rr_ptr), 64'h1);

        // Bring pointer to 0 via the bp slot
        set_req(3, 9); expect_bc(9, CDB_BP);
        tick();
        req_valid = '0;
        tick();
        chk("ptr_wrap0", 64'(dut.r_rr_ptr), 64'h0);

        // Four simultaneous requests, ptr=0
        for (int i = 0; i < 4; i++) begin
            set_req(i, i + 1);
            expect_bc(i + 1, cdb_src_t'(i));
        end
        tick();
        req_valid = '0;
        #1;
        chk("four_ready_c1", 64'(req_ready), 64'b0001);
        tick();
        chk("four_ready_c2", 64'(req_ready), 64'b0011);
        tick();
        chk("four_ready_c3", 64'(req_ready), 64'b0111);
        tick();
        chk("four_ready_c4", 64'(req_ready), 64'b1111);
        tick();
        chk("four_ptr", 64'(dut.r_rr_ptr), 64'h0);

        // Move pointer to 3, then slots 0 and 3 together
        set_req(2, 7); expect_bc(7, CDB_LSQ);
        tick();
        req_valid = '0;
        tick();
        chk("wrap_ptr3", 64'(dut.r_rr_ptr), 64'h3);
        set_req(0, 10); set_req(3, 11);
        expect_bc(11, CDB_BP); expect_bc(10, CDB_ADD);
        tick();
        req_valid = '0;
        tick();
        chk("wrap_ptr_after3", 64'(dut.r_rr_ptr), 64'h0);
        tick();
        chk("wrap_ptr_after0", 64'(dut.r_rr_ptr), 64'h1);

        // Back-to-back streaming from mul
        for (int k = 0; k < 6; k++) begin
            req_valid = '0;
            set_req(1, 20 + k); expect_bc(20 + k, CDB_MUL);
            #1;
            chk("stream_ready", 64'(req_ready[1]), 64'h1);
            if (k > 0) chk("stream_nobubble", 64'(cdb_valid), 64'h1);
            tick();
        end
        req_valid = '0;
        tick();
        chk("stream_ptr", 64'(dut.r_rr_ptr), 64'h2);

        // Flush with three slots occupied; incoming bp request is dropped
        set_req(0, 12); set_req(1, 13); set_req(2, 14);
        tick();
        req_valid = '0;
        set_req(3, 30);
        flush = 1'b1;
        #1;
        chk("flush_valid", 64'(cdb_valid), 64'h0);
        chk("flush_ready", 64'(req_ready), 64'h0);
        chk("flush_grant", 64'(cdb_grant), 64'h0);
        tick();
        flush = 1'b0; req_valid = '0;
        #1;
        chk("postflush_hold", 64'(dut.r_hold_v), 64'h0);
        chk("postflush_valid", 64'(cdb_valid), 64'h0);
        chk("postflush_ptr", 64'(dut.r_rr_ptr), 64'h2);
        chk("postflush_ready", 64'(req_ready), 64'hF);
        set_req(1, 15); expect_bc(15, CDB_MUL);
        tick();
        req_valid = '0;
        tick();

        // Reset mid-drain with two slots still pending
        set_req(0, 16); set_req(2, 18); set_req(3, 17);
        expect_bc(18, CDB_LSQ);
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(cdb_valid), 64'h0);
        chk("midrst_ptr",   64'(dut.r_rr_ptr), 64'h0);
        chk("midrst_ready", 64'(req_ready), 64'hF);
        tick(); tick(); tick();
        chk("sb_empty", 64'(sb_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
